// File: rtl/y86_alu.sv
// y86_alu -- Y86-64 execute-stage ALU with condition-code register.
//
// Purpose:
//   Computes add/sub/and/xor on two 64-bit operands with zero-cycle latency,
//   reports signed overflow, and optionally latches zero/sign/overflow flags
//   into a condition-code register. A branch/move condition is evaluated
//   combinationally from the latched flags.
//
// Ports:
//   clk      in   1   rising-edge clock, used only by the flag register
//   rst_n    in   1   asynchronous active-low reset, clears the flags
//   control  in   2   0=add, 1=sub (A-B), 2=and, 3=xor
//   A, B     in   64  operands, signed two's complement
//   set_cc   in   1   capture this cycle's flags on the next rising edge
//   cond_fn  in   4   condition select (0 always, 1 le, 2 l, 3 e, 4 ne,
//                     5 ge, 6 g, 7..15 never)
//   result   out  64  operation result (combinational, wraps mod 2^64)
//   overflow out  1   signed overflow of the current operation
//   zf,sf,of out  1   registered zero / sign / overflow flags
//   cnd      out  1   condition evaluated from the registered flags
module y86_alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  control,
    input  logic [63:0] A,
    input  logic [63:0] B,
    input  logic        set_cc,
    input  logic [3:0]  cond_fn,
    output logic [63:0] result,
    output logic        overflow,
    output logic        zf,
    output logic        sf,
    output logic        of,
    output logic        cnd
);

    logic [63:0] w_sum;
    logic [63:0] w_diff;
    logic [63:0] w_result;
    logic        w_overflow;
    logic        w_lt;
    logic        w_cnd;

    logic        r_zf;
    logic        r_sf;
    logic        r_of;

    assign w_sum  = A + B;
    assign w_diff = A - B;

    // Overflow: operands of the "effective" same sign produce a result whose
    // sign differs from A. For subtraction B is negated, so the operand signs
    // must differ instead.
    always_comb begin
        w_result   = '0;
        w_overflow = 1'b0;
        case (control)
            2'd0: begin
                w_result   = w_sum;
                w_overflow = (A[63] == B[63]) && (w_sum[63] != A[63]);
            end
            2'd1: begin
                w_result   = w_diff;
                w_overflow = (A[63] != B[63]) && (w_diff[63] != A[63]);
            end
            2'd2: begin
                w_result = A & B;
            end
            default: begin
                w_result = A ^ B;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zf <= 1'b0;
            r_sf <= 1'b0;
            r_of <= 1'b0;
        end else if (set_cc) begin
            r_zf <= (w_result == 64'd0);
            r_sf <= w_result[63];
            r_of <= w_overflow;
        end
    end

    // Signed "less than" of the operation that set the flags.
    assign w_lt = r_sf ^ r_of;

    always_comb begin
        w_cnd = 1'b0;
        case (cond_fn)
            4'd0:    w_cnd = 1'b1;
            4'd1:    w_cnd = w_lt | r_zf;
            4'd2:    w_cnd = w_lt;
            4'd3:    w_cnd = r_zf;
            4'd4:    w_cnd = ~r_zf;
            4'd5:    w_cnd = ~w_lt;
            4'd6:    w_cnd = ~w_lt & ~r_zf;
            default: w_cnd = 1'b0;
        endcase
    end

    assign result   = w_result;
    assign overflow = w_overflow;
    assign zf       = r_zf;
    assign sf       = r_sf;
    assign of       = r_of;
    assign cnd      = w_cnd;

endmodule

// File: tb/tb_y86_alu.sv
// tb_y86_alu -- self-checking bench for y86_alu.
//
// Purpose:
//   Drives directed vectors, hand-written flag/reset sequences and random
//   operations, comparing against a reference model computed from plain
//   signed arithmetic on widened operands.
//
// Ports: none (top-level bench).
module tb_y86_alu;

    logic        clk;
    logic        rst_n;
    logic [1:0]  control;
    logic [63:0] a;
    logic [63:0] b;
    logic        set_cc;
    logic [3:0]  cond_fn;
    logic [63:0] result;
    logic        overflow;
    logic        zf;
    logic        sf;
    logic        of;
    logic        cnd;

    int total = 0;
    int bad   = 0;

    // Reference flag state.
    logic m_zf = 1'b0;
    logic m_sf = 1'b0;
    logic m_of = 1'b0;

    logic [63:0] exp_q[$];

    typedef struct {
        logic [1:0]  ctl;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic        ovf;
    } vec_t;

    vec_t vecs[10];

    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    y86_alu dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .control  (control),
        .A        (a),
        .B        (b),
        .set_cc   (set_cc),
        .cond_fn  (cond_fn),
        .result   (result),
        .overflow (overflow),
        .zf       (zf),
        .sf       (sf),
        .of       (of),
        .cnd      (cnd)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Exact signed arithmetic in 65 bits; overflow means the true value does
    // not fit in a signed 64-bit range.
    function automatic void ref_op(input logic [1:0] c, input logic [63:0] x,
                                   input logic [63:0] y, output logic [63:0] r,
                                   output logic ov);
        logic signed [64:0] wide;
        logic signed [64:0] lo;
        logic signed [64:0] hi;
        lo = -(65'sd1 <<< 63);
        hi = (65'sd1 <<< 63) - 65'sd1;
        r  = '0;
        ov = 1'b0;
        case (c)
            2'd0: begin
                wide = $signed({x[63], x}) + $signed({y[63], y});
                r    = wide[63:0];
                ov   = (wide < lo) || (wide > hi);
            end
            2'd1: begin
                wide = $signed({x[63], x}) - $signed({y[63], y});
                r    = wide[63:0];
                ov   = (wide < lo) || (wide > hi);
            end
            2'd2: r = x & y;
            default: r = x ^ y;
        endcase
    endfunction

    function automatic logic ref_cnd(input logic [3:0] fn, input logic z,
                                     input logic s, input logic o);
        logic less;
        less = (s != o);
        case (fn)
            4'd0:    return 1'b1;
            4'd1:    return less || z;
            4'd2:    return less;
            4'd3:    return z;
            4'd4:    return !z;
            4'd5:    return !less;
            4'd6:    return !less && !z;
            default: return 1'b0;
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Full check of all outputs against the model at the current inputs.
    task automatic check_all(input string tag);
        logic [63:0] r;
        logic        ov;
        ref_op(control, a, b, r, ov);
        exp_q.push_back(r);
        chk({tag, ".result"}, result, exp_q.pop_front());
        chk({tag, ".overflow"}, {63'd0, overflow}, {63'd0, ov});
        chk({tag, ".zf"}, {63'd0, zf}, {63'd0, m_zf});
        chk({tag, ".sf"}, {63'd0, sf}, {63'd0, m_sf});
        chk({tag, ".of"}, {63'd0, of}, {63'd0, m_of});
        chk({tag, ".cnd"}, {63'd0, cnd}, {63'd0, ref_cnd(cond_fn, m_zf, m_sf, m_of)});
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input logic [1:0] c, input logic [63:0] x, input logic [63:0] y,
                         input logic scc, input logic [3:0] fn);
        @(negedge clk);
        control = c;
        a       = x;
        b       = y;
        set_cc  = scc;
        cond_fn = fn;
        #1;
    endtask

    // One rising edge; model captures flags from the inputs present at it.
    task automatic tick();
        logic [63:0] r;
        logic        ov;
        ref_op(control, a, b, r, ov);
        @(posedge clk);
        if (rst_n && set_cc) begin
            m_zf = (r == 64'd0);
            m_sf = r[63];
            m_of = ov;
        end
        #1;
    endtask

    task automatic set_fn(input logic [3:0] fn);
        cond_fn = fn;
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] ra;
        logic [63:0] rb;

        rst_n   = 1'b0;
        control = 2'd0;
        a       = '0;
        b       = '0;
        set_cc  = 1'b0;
        cond_fn = 4'd0;

        vecs[0] = '{2'd0, 64'd5,    64'd7,    64'd12,   1'b0};
        vecs[1] = '{2'd0, MAXP,     64'd1,    MINN,     1'b1};
        vecs[2] = '{2'd1, 64'd9,    64'd9,    64'd0,    1'b0};
        vecs[3] = '{2'd1, MINN,     64'd1,    MAXP,     1'b1};
        vecs[4] = '{2'd2, 64'hF0,   64'h3C,   64'h30,   1'b0};
        vecs[5] = '{2'd3, 64'hF0,   64'h3C,   64'hCC,   1'b0};
        vecs[6] = '{2'd0, ONES,     64'd1,    64'd0,    1'b0};
        vecs[7] = '{2'd0, MINN,     ONES,     MAXP,     1'b1};
        vecs[8] = '{2'd1, 64'd0,    MINN,     MINN,     1'b1};
        vecs[9] = '{2'd1, 64'd3,    64'd5,    64'hFFFF_FFFF_FFFF_FFFE, 1'b0};

        // Reset state, before any clock edge.
        #2;
        chk("reset.zf", {63'd0, zf}, 64'd0);
        chk("reset.sf", {63'd0, sf}, 64'd0);
        chk("reset.of", {63'd0, of}, 64'd0);
        chk("reset.cnd0", {63'd0, cnd}, 64'd1);

        // Edge with set_cc=0 after release must not capture; next one with
        // set_cc=1 must.
        drive(2'd1, 64'd1, 64'd2, 1'b0, 4'd2);
        rst_n = 1'b1;
        tick();
        check_all("post_reset_hold");
        chk("post_reset_hold.sf", {63'd0, sf}, 64'd0);
        set_cc = 1'b1;
        tick();
        chk("first_capture.sf", {63'd0, sf}, 64'd1);
        check_all("first_capture");

        // Directed table: combinational result/overflow then captured flags.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].ctl, vecs[i].a, vecs[i].b, 1'b1, 4'd0);
            chk($sformatf("vec%0d.result", i), result, vecs[i].res);
            chk($sformatf("vec%0d.overflow", i), {63'd0, overflow}, {63'd0, vecs[i].ovf});
            tick();
            chk($sformatf("vec%0d.zf", i), {63'd0, zf}, {63'd0, vecs[i].res == 64'd0});
            chk($sformatf("vec%0d.sf", i), {63'd0, sf}, {63'd0, vecs[i].res[63]});
            chk($sformatf("vec%0d.of", i), {63'd0, of}, {63'd0, vecs[i].ovf});
        end

        // Add overflow: same-cycle op must not change cnd before the edge.
        drive(2'd1, 64'd1, 64'd1, 1'b1, 4'd2);
        tick();                       // flags: zf=1, sf=0, of=0
        drive(2'd0, MAXP, 64'd1, 1'b1, 4'd2);
        chk("same_cycle.cnd_l", {63'd0, cnd}, 64'd0);
        chk("same_cycle.zf", {63'd0, zf}, 64'd1);
        tick();
        chk("add_ovf.sf", {63'd0, sf}, 64'd1);
        chk("add_ovf.of", {63'd0, of}, 64'd1);
        chk("add_ovf.cnd_l", {63'd0, cnd}, 64'd0);

        // Equal subtract.
        drive(2'd1, 64'd9, 64'd9, 1'b1, 4'd3);
        tick();
        chk("eq_sub.zf", {63'd0, zf}, 64'd1);
        chk("eq_sub.cnd_e", {63'd0, cnd}, 64'd1);
        set_fn(4'd4);
        chk("eq_sub.cnd_ne", {63'd0, cnd}, 64'd0);
        set_fn(4'd1);
        chk("eq_sub.cnd_le", {63'd0, cnd}, 64'd1);

        // Flag hold then mid-cycle asynchronous reset.
        drive(2'd1, 64'd3, 64'd5, 1'b1, 4'd2);
        tick();
        chk("hold.sf_set", {63'd0, sf}, 64'd1);
        drive(2'd0, 64'd100, 64'd200, 1'b0, 4'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("hold%0d.sf", i), {63'd0, sf}, 64'd1);
            chk($sformatf("hold%0d.zf", i), {63'd0, zf}, 64'd0);
            chk($sformatf("hold%0d.cnd_l", i), {63'd0, cnd}, 64'd1);
        end
        #1;
        rst_n = 1'b0;
        m_zf  = 1'b0;
        m_sf  = 1'b0;
        m_of  = 1'b0;
        #1;
        chk("async_rst.sf", {63'd0, sf}, 64'd0);
        chk("async_rst.result", result, 64'd300);
        chk("async_rst.overflow", {63'd0, overflow}, 64'd0);
        set_fn(4'd6);
        chk("async_rst.cnd_g", {63'd0, cnd}, 64'd1);
        set_fn(4'd7);
        chk("async_rst.cnd_7", {63'd0, cnd}, 64'd0);
        set_cc = 1'b1;
        tick();                       // edge in reset: no capture
        check_all("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Randomized stimulus against the model.
        for (int i = 0; i < 300; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: ra = MAXP;
                1: ra = MINN;
                2: rb = ra;
                3: rb = ONES;
                default: ;
            endcase
            drive(2'($urandom_range(0, 3)), ra, rb, 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)));
            check_all($sformatf("rnd%0d.pre", i));
            tick();
            check_all($sformatf("rnd%0d.post", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
